ps2_rx_fifo: RTL and testbench

Parametrised PS/2-style serial receiver for the keyboard/touch input path. It runs in the system clock domain and synchronises the external device clock and data lines. Each frame carries a start bit, DATA_W data bits LSB-first, an optional parity bit and a stop bit. Good words are buffered in a small FIFO with a valid/ready handshake, and errors are reported with a cause code. It supersedes the single-byte, unbuffered receiver in the input chain.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_sync_fifo.sv | 63 ++++++
 rtl/ps2_rx_fifo.sv | 156 +++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_pkg : shared error codes, parity modes and receive FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [1:0] ERR_OVR = 2'd0;
  localparam logic [1:0] ERR_PAR = 2'd1;
  localparam logic [1:0] ERR_FRM = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_sync_fifo : show-ahead FIFO; dout holds the last popped word when empty.
// Rev 1.0
// ---------------------------------------------------------------------------
module ps2_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [W-1:0]  last_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? last_q : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_rx_fifo : PS/2-style frame receiver with parity/timeout checks and FIFO.
// Rev 1.0
// ---------------------------------------------------------------------------
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PARITY  = 1,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                   CLKOUT,
  input  logic                   RESET_N,
  input  logic                   PS2_CLK,
  input  logic                   Rx,
  output logic [DATA_W-1:0]      DATA,
  output logic                   VALID,
  input  logic                   READY,
  output logic                   Rx_error,
  output logic [1:0]             ERR_CODE,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] LEVEL
);

  localparam int IW = $clog2(DATA_W);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]        clk_sync_q;
  logic [1:0]        rx_sync_q;
  logic              clk_prev_q;
  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              fe;
  logic              rx_s;
  logic              timeout;
  logic              par_ok;
  logic              push;
  logic              empty;
  logic              full;

  assign fe      = clk_prev_q & ~clk_sync_q[1];
  assign rx_s    = rx_sync_q[1];
  assign timeout = (state_q != ST_IDLE) && !fe && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    par_ok = 1'b1;
    if (PARITY == PAR_ODD)       par_ok = ^{shift_q, par_q};
    else if (PARITY == PAR_EVEN) par_ok = ~^{shift_q, par_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    err_d   = 1'b0;
    code_d  = code_q;
    push    = 1'b0;
    tmo_d   = (state_q == ST_IDLE || fe) ? '0 : tmo_q + 1'b1;
    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      tmo_d   = '0;
    end else if (fe) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IW'(DATA_W - 1)) state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
        end
        ST_PAR: begin
          par_d   = rx_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!rx_s) begin
            err_d  = 1'b1;
            code_d = ERR_FRM;
          end else if (!par_ok) begin
            err_d  = 1'b1;
            code_d = ERR_PAR;
          end else if (full && !READY) begin
            err_d  = 1'b1;
            code_d = ERR_OVR;
          end else begin
            push = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLKOUT) begin
    if (!RESET_N) begin
      clk_sync_q <= '0;
      rx_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      rx_sync_q  <= {rx_sync_q[0], Rx};
      clk_prev_q <= clk_sync_q[1];
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  ps2_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLKOUT),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (READY),
    .din   (shift_q),
    .dout  (DATA),
    .empty (empty),
    .full  (full),
    .level (LEVEL)
  );

  assign VALID    = !empty;
  assign Rx_error = err_q;
  assign ERR_CODE = code_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo : frame-level reference model plus directed and random frames.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

  localparam int DATA_W  = 8;
  localparam int PARITY  = 1;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int NB      = DATA_W + ((PARITY != 0) ? 1 : 0) + 1;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              ps2c  = 1'b1;
  logic              rx    = 1'b1;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              rx_error;
  logic [1:0]        err_code;
  logic              busy;
  logic [LW-1:0]     level;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .DATA_W  (DATA_W),
    .PARITY  (PARITY),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLKOUT   (clk),
    .RESET_N  (rst_n),
    .PS2_CLK  (ps2c),
    .Rx       (rx),
    .DATA     (data),
    .VALID    (valid),
    .READY    (ready),
    .Rx_error (rx_error),
    .ERR_CODE (err_code),
    .BUSY     (busy),
    .LEVEL    (level)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit rand_en = 1'b0;
  int got_w[$];
  int got_e[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: device pins -> 2-flop sync -> frame bit list -> word queue.
  bit m_s1, m_s2, m_prev, m_r1, m_r2;
  bit m_busy;
  int m_tmo;
  bit m_bits[$];
  int m_q[$];
  int m_last;
  bit m_err;
  int m_code;
  bit m_fe, m_rs, m_pop, m_push;
  int m_w, m_ones;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_r1 = 0; m_r2 = 0;
      m_busy = 0; m_tmo = 0; m_bits.delete(); m_q.delete();
      m_last = 0; m_err = 0; m_code = 0;
    end else begin
      m_fe   = m_prev && !m_s2;
      m_rs   = m_r2;
      m_pop  = ready && (m_q.size() > 0);
      m_push = 0;
      m_err  = 0;
      if (m_busy) begin
        if (m_fe) begin
          m_tmo = 0;
          m_bits.push_back(m_rs);
          if (m_bits.size() == NB) begin
            m_busy = 0;
            m_w = 0;
            m_ones = 0;
            for (int i = 0; i < DATA_W; i++) if (m_bits[i]) begin m_w += (1 << i); m_ones++; end
            if (PARITY != 0 && m_bits[DATA_W]) m_ones++;
            if (!m_bits[NB-1]) begin m_err = 1; m_code = 2; end
            else if ((PARITY == 1 && m_ones % 2 == 0) || (PARITY == 2 && m_ones % 2 == 1)) begin
              m_err = 1; m_code = 1;
            end else if (m_q.size() == DEPTH && !m_pop) begin m_err = 1; m_code = 0; end
            else m_push = 1;
          end
        end else if (m_tmo == TIMEOUT - 1) begin
          m_err = 1; m_code = 3; m_busy = 0; m_tmo = 0;
        end else begin
          m_tmo++;
        end
      end else if (m_fe && !m_rs) begin
        m_busy = 1;
        m_bits.delete();
        m_tmo = 0;
      end
      if (m_pop) m_last = m_q.pop_front();
      if (m_push) m_q.push_back(m_w);
      m_prev = m_s2; m_s2 = m_s1; m_s1 = ps2c;
      m_r2 = m_r1; m_r1 = rx;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("VALID", valid, m_q.size() > 0);
      chk("DATA", data, (m_q.size() > 0) ? m_q[0] : m_last);
      chk("LEVEL", level, m_q.size());
      chk("BUSY", busy, m_busy);
      chk("Rx_error", rx_error, m_err);
      if (m_err) chk("ERR_CODE", err_code, m_code);
      if (valid && ready) got_w.push_back(data);
      if (rx_error) got_e.push_back(err_code);
    end
  end

  int half = 10;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input bit b);
    rx = b;
    tick(half / 2);
    ps2c = 1'b0;
    tick(half);
    ps2c = 1'b1;
    tick(half / 2);
  endtask

  task automatic send_frame(input int w, input bit bad_par, input bit stop);
    logic [DATA_W-1:0] d;
    bit p;
    d = w[DATA_W-1:0];
    p = (PARITY == 1) ? ~^d : ^d;
    if (bad_par) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    if (PARITY != 0) send_bit(p);
    send_bit(stop);
    rx = 1'b1;
    tick(4);
  endtask

  initial begin
    int first;
    int r;
    logic [DATA_W-1:0] d;
    tick(3);
    chk_en = 1'b1;
    tick(2);
    chk("rst VALID", valid, 0);
    chk("rst DATA", data, 0);
    chk("rst LEVEL", level, 0);
    chk("rst BUSY", busy, 0);
    chk("rst Rx_error", rx_error, 0);
    chk("rst ERR_CODE", err_code, 0);
    rst_n = 1'b1;
    tick(5);

    // good frame, consumer always ready
    ready = 1'b1;
    got_w.delete(); got_e.delete();
    send_frame('h5A, 1'b0, 1'b1);
    tick(5);
    chk("t1 word count", got_w.size(), 1);
    chk("t1 word", (got_w.size() > 0) ? got_w[0] : -1, 'h5A);
    chk("t1 error count", got_e.size(), 0);

    // parity error
    got_w.delete(); got_e.delete();
    send_frame('h5A, 1'b1, 1'b1);
    tick(5);
    chk("t2 error count", got_e.size(), 1);
    chk("t2 code", (got_e.size() > 0) ? got_e[0] : -1, 1);
    chk("t2 word count", got_w.size(), 0);
    chk("t2 LEVEL", level, 0);

    // framing error
    got_w.delete(); got_e.delete();
    send_frame('h12, 1'b0, 1'b0);
    tick(5);
    chk("t3 error count", got_e.size(), 1);
    chk("t3 code", (got_e.size() > 0) ? got_e[0] : -1, 2);
    chk("t3 word count", got_w.size(), 0);

    // timeout after the 4th data bit
    got_w.delete(); got_e.delete();
    d = 8'h34;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    tick(half / 2);
    ps2c = 1'b0;
    first = 0;
    for (int k = 1; k <= 200; k++) begin
      tick(1);
      if (k == 10) ps2c = 1'b1;
      if (rx_error) begin
        first = k;
        break;
      end
    end
    rx = 1'b1;
    chk("t4 timeout latency", first, 103);
    tick(2);
    chk("t4 BUSY", busy, 0);
    chk("t4 code", (got_e.size() > 0) ? got_e[0] : -1, 3);
    send_frame('h34, 1'b0, 1'b1);
    tick(5);
    chk("t4 word count", got_w.size(), 1);
    chk("t4 word", (got_w.size() > 0) ? got_w[0] : -1, 'h34);

    // overrun
    ready = 1'b0;
    got_w.delete(); got_e.delete();
    for (int v = 1; v <= 5; v++) send_frame(v, 1'b0, 1'b1);
    tick(3);
    chk("t5 LEVEL", level, 4);
    chk("t5 error count", got_e.size(), 1);
    chk("t5 code", (got_e.size() > 0) ? got_e[0] : -1, 0);
    ready = 1'b1;
    tick(10);
    chk("t5 word count", got_w.size(), 4);
    for (int v = 0; v < 4; v++) chk("t5 pop order", (got_w.size() > v) ? got_w[v] : -1, v + 1);

    // reset mid-frame with two words stored
    ready = 1'b0;
    send_frame('h11, 1'b0, 1'b1);
    send_frame('h22, 1'b0, 1'b1);
    chk("t6 LEVEL before", level, 2);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk("t6 VALID", valid, 0);
    chk("t6 DATA", data, 0);
    chk("t6 LEVEL", level, 0);
    chk("t6 BUSY", busy, 0);
    chk("t6 Rx_error", rx_error, 0);
    rst_n = 1'b1;
    tick(5);
    got_w.delete(); got_e.delete();
    ready = 1'b1;
    send_frame('hA5, 1'b0, 1'b1);
    tick(5);
    chk("t6 word count", got_w.size(), 1);
    chk("t6 word", (got_w.size() > 0) ? got_w[0] : -1, 'hA5);
    chk("t6 error count", got_e.size(), 0);

    // randomized frames, errors and back-pressure
    rand_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      half = 2 * $urandom_range(3, 8);
      r = $urandom_range(0, 9);
      if (r == 0) send_frame($urandom, 1'b1, 1'b1);
      else if (r == 1) send_frame($urandom, 1'b0, 1'b0);
      else if (r == 2) begin
        send_bit(1'b0);
        for (int i = 0; i < $urandom_range(0, NB - 2); i++) send_bit($urandom_range(0, 1) == 1);
        rx = 1'b1;
        tick(TIMEOUT + 40);
      end else if (r == 3) begin
        send_bit(1'b1);
        tick(3);
      end else begin
        send_frame($urandom, 1'b0, 1'b1);
      end
      tick($urandom_range(0, 20));
    end
    rand_en = 1'b0;
    ready = 1'b1;
    tick(50);
    chk("final LEVEL", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    wait (rand_en);
    while (rand_en) begin
      tick(1);
      if (rand_en) ready = ($urandom_range(0, 3) == 0);
    end
  end

endmodule
`default_nettype wire
